// File: rtl/calc1_req_issuer.sv
// Purpose: upstream request stage for one calc1 port; buffers host requests and replays them as cmd+op1 / 0+op2, then returns the response.
// Latency: a push at edge N onto an empty FIFO drives ISSUE1 after edge N+1; the result is valid after the edge that samples a nonzero calc1 response.
// Backpressure: req_ready depends only on FIFO occupancy. A held result stalls further issue until it is accepted with rsp_ready.
//
// Ports: host request (req_*, valid/ready), calc1 request/response pair (calc_*), result (rsp_*, valid/ready), busy.
// Optional macro CALC1_TIMEOUT_EN: WAIT ends with rsp_code=3 after TIMEOUT_CYCLES cycles without a response.
// Only one calc1 operation is outstanding at a time; every calc-side and result-side output comes straight from a register.
module calc1_req_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:3]  req_cmd,
    input  logic [0:31] req_op1,
    input  logic [0:31] req_op2,
    output logic [0:3]  calc_cmd_out,
    output logic [0:31] calc_data_out,
    input  logic [0:1]  calc_resp_in,
    input  logic [0:31] calc_data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:1]  rsp_code,
    output logic [0:31] rsp_data,
    output logic [0:3]  rsp_cmd,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // The pointers wrap by natural overflow, so the depth must be a power of two.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("calc1_req_issuer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_ISSUE2,
        S_WAIT,
        S_HOLD
    } state_t;

    // ---------------- request FIFO ----------------
    req_t          fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    req_t          req_in, head;

    assign req_ready = (count_q != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign req_in    = '{cmd: req_cmd, op1: req_op1, op2: req_op2};
    assign head      = fifo_mem_q[rd_ptr_q];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge c_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= req_in;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ---------------- issue FSM ----------------
    state_t      state_q, state_d;
    logic [3:0]  calc_cmd_q, calc_cmd_d;
    logic [31:0] calc_data_q, calc_data_d;
    logic [3:0]  cur_cmd_q, cur_cmd_d;
    logic [31:0] op2_q, op2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_code_q, rsp_code_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_cmd_q, rsp_cmd_d;

`ifdef CALC1_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        // The calc1 bus idles at zero; only the two issue cycles drive it.
        calc_cmd_d  = '0;
        calc_data_d = '0;
        cur_cmd_d   = cur_cmd_q;
        op2_d       = op2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_code_d  = rsp_code_q;
        rsp_data_d  = rsp_data_q;
        rsp_cmd_d   = rsp_cmd_q;
`ifdef CALC1_TIMEOUT_EN
        tmo_d       = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    cur_cmd_d = head.cmd;
                    op2_d     = head.op2;
                    if (head.cmd == 4'd0) begin
                        // cmd 0 cannot be told apart from an idle calc1 cycle, so answer locally.
                        state_d     = S_HOLD;
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = 2'd2;
                        rsp_data_d  = '0;
                        rsp_cmd_d   = 4'd0;
                    end else begin
                        state_d     = S_ISSUE1;
                        calc_cmd_d  = head.cmd;
                        calc_data_d = head.op1;
                    end
                end
            end
            S_ISSUE1: begin
                state_d     = S_ISSUE2;
                calc_data_d = op2_q;
            end
            S_ISSUE2: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (calc_resp_in != 2'd0) begin
                    state_d     = S_HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = calc_resp_in;
                    rsp_data_d  = calc_data_in;
                    rsp_cmd_d   = cur_cmd_q;
                end
`ifdef CALC1_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d     = S_HOLD;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = 2'd3;
                    rsp_data_d  = '0;
                    rsp_cmd_d   = cur_cmd_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            calc_cmd_q  <= '0;
            calc_data_q <= '0;
            cur_cmd_q   <= '0;
            op2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= '0;
            rsp_data_q  <= '0;
            rsp_cmd_q   <= '0;
`ifdef CALC1_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q     <= count_d;
            calc_cmd_q  <= calc_cmd_d;
            calc_data_q <= calc_data_d;
            cur_cmd_q   <= cur_cmd_d;
            op2_q       <= op2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cmd_q   <= rsp_cmd_d;
`ifdef CALC1_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign calc_cmd_out  = calc_cmd_q;
    assign calc_data_out = calc_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_code      = rsp_code_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_cmd       = rsp_cmd_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_calc1_req_issuer.sv
// Purpose: directed self-checking bench for calc1_req_issuer.
// Latency: the bench drives and samples 1 time unit after each rising edge; the calc1 response is driven by hand.
// Backpressure: rsp_ready is held low to fill the FIFO, then raised to drain the queued results in order.
module tb_calc1_req_issuer;

    logic        c_clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [0:3]  req_cmd;
    logic [0:31] req_op1;
    logic [0:31] req_op2;
    logic [0:3]  calc_cmd_out;
    logic [0:31] calc_data_out;
    logic [0:1]  calc_resp_in;
    logic [0:31] calc_data_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic [0:3]  rsp_cmd;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    calc1_req_issuer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .calc_cmd_out  (calc_cmd_out),
        .calc_data_out (calc_data_out),
        .calc_resp_in  (calc_resp_in),
        .calc_data_in  (calc_data_in),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_code      (rsp_code),
        .rsp_data      (rsp_data),
        .rsp_cmd       (rsp_cmd),
        .busy          (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_calc_cmd"},  32'(calc_cmd_out),  32'd0);
        chk({tag, "_calc_data"}, 32'(calc_data_out), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid),     32'd0);
        chk({tag, "_rsp_code"},  32'(rsp_code),      32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),      32'd0);
        chk({tag, "_rsp_cmd"},   32'(rsp_cmd),       32'd0);
        chk({tag, "_busy"},      32'(busy),          32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready),     32'd1);
    endtask

    task automatic push_req(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_op1   = op1;
        req_op2   = op2;
        step();
        req_valid = 1'b0;
    endtask

    logic [3:0] t3_cmd [6];
    int         idx;
    int         seen;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_cmd      = '0;
        req_op1      = '0;
        req_op2      = '0;
        calc_resp_in = '0;
        calc_data_in = '0;
        rsp_ready    = 1'b0;
        t3_cmd       = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9};

        // 1. reset held for 4 cycles, then released
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_quiet("t1_rst");
        end
        reset = 1'b1;
        step();
        chk_quiet("t1_rel");

        // a response while idle must be ignored
        calc_resp_in = 2'd1;
        calc_data_in = 32'h99;
        step();
        step();
        chk("t1_stray_valid", 32'(rsp_valid), 32'd0);
        chk("t1_stray_busy",  32'(busy),      32'd0);
        calc_resp_in = 2'd0;
        calc_data_in = '0;

        // 2. add 0x1 + 0x1FFFFFFF, response 3 cycles into WAIT
        chk("t2_ready", 32'(req_ready), 32'd1);
        push_req(4'd1, 32'h1, 32'h1FFF_FFFF);              // E0
        chk("t2_e0_cmd",  32'(calc_cmd_out), 32'd0);
        chk("t2_e0_busy", 32'(busy),         32'd1);
        step();                                             // E1: ISSUE1
        chk("t2_iss1_cmd",  32'(calc_cmd_out),  32'd1);
        chk("t2_iss1_data", 32'(calc_data_out), 32'h1);
        step();                                             // E2: ISSUE2
        chk("t2_iss2_cmd",  32'(calc_cmd_out),  32'd0);
        chk("t2_iss2_data", 32'(calc_data_out), 32'h1FFF_FFFF);
        step();                                             // E3: WAIT
        chk("t2_wait_cmd",  32'(calc_cmd_out),  32'd0);
        chk("t2_wait_data", 32'(calc_data_out), 32'd0);
        step();
        step();
        chk("t2_wait_valid", 32'(rsp_valid), 32'd0);
        calc_resp_in = 2'd1;
        calc_data_in = 32'h2000_0000;
        step();
        calc_resp_in = 2'd0;
        calc_data_in = '0;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_code",  32'(rsp_code),  32'd1);
        chk("t2_rsp_data",  32'(rsp_data),  32'h2000_0000);
        chk("t2_rsp_cmd",   32'(rsp_cmd),   32'd1);
        step();
        chk("t2_hold_valid", 32'(rsp_valid), 32'd1);
        chk("t2_hold_data",  32'(rsp_data),  32'h2000_0000);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t2_ack_valid", 32'(rsp_valid), 32'd0);
        chk("t2_ack_busy",  32'(busy),      32'd0);

        // 3. consumer stalled, calc1 always answers: 6 back-to-back pushes
        calc_resp_in = 2'd1;
        calc_data_in = 32'h55;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_cmd   = t3_cmd[i];
            req_op1   = 32'(i + 16);
            req_op2   = 32'(i + 32);
            chk("t3_push_ready", 32'(req_ready), (i < 5) ? 32'd1 : 32'd0);
            step();
        end
        req_valid = 1'b0;
        chk("t3_full_valid", 32'(rsp_valid), 32'd1);
        chk("t3_full_cmd",   32'(rsp_cmd),   32'd1);
        chk("t3_full_ready", 32'(req_ready), 32'd0);
        chk("t3_full_busy",  32'(busy),      32'd1);
        step();
        step();
        step();
        chk("t3_stall_valid", 32'(rsp_valid), 32'd1);
        chk("t3_stall_cmd",   32'(rsp_cmd),   32'd1);
        chk("t3_stall_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 100 && idx < 5; c++) begin
            if (rsp_valid) begin
                chk("t3_drain_cmd",  32'(rsp_cmd),  32'(t3_cmd[idx]));
                chk("t3_drain_code", 32'(rsp_code), 32'd1);
                chk("t3_drain_data", 32'(rsp_data), 32'h55);
                idx++;
            end
            step();
        end
        chk("t3_drain_count", 32'(idx), 32'd5);
        calc_resp_in = 2'd0;
        calc_data_in = '0;
        rsp_ready    = 1'b0;
        step();
        chk("t3_end_busy",  32'(busy),      32'd0);
        chk("t3_end_ready", 32'(req_ready), 32'd1);
        chk("t3_end_valid", 32'(rsp_valid), 32'd0);

        // 4. cmd 0 is answered locally with code 2 and no calc1 traffic
        push_req(4'd0, 32'hAAAA, 32'hBBBB);
        chk("t4_e0_cmd",  32'(calc_cmd_out),  32'd0);
        chk("t4_e0_data", 32'(calc_data_out), 32'd0);
        step();
        chk("t4_valid",     32'(rsp_valid),     32'd1);
        chk("t4_code",      32'(rsp_code),      32'd2);
        chk("t4_data",      32'(rsp_data),      32'd0);
        chk("t4_cmd",       32'(rsp_cmd),       32'd0);
        chk("t4_calc_cmd",  32'(calc_cmd_out),  32'd0);
        chk("t4_calc_data", 32'(calc_data_out), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t4_ack_valid", 32'(rsp_valid), 32'd0);

        // 5. calc1 stays silent
        push_req(4'd2, 32'd5, 32'd3);                       // E0
        step();                                             // E1: ISSUE1
        chk("t5_iss1_cmd", 32'(calc_cmd_out), 32'd2);
        step();                                             // E2
        step();                                             // E3: WAIT entered
`ifdef CALC1_TIMEOUT_EN
        repeat (15) step();                                 // E18: 15 WAIT cycles done
        chk("t5_pre_tmo_valid", 32'(rsp_valid), 32'd0);
        step();                                             // E19: 16th WAIT cycle
        chk("t5_tmo_valid", 32'(rsp_valid), 32'd1);
        chk("t5_tmo_code",  32'(rsp_code),  32'd3);
        chk("t5_tmo_data",  32'(rsp_data),  32'd0);
        chk("t5_tmo_cmd",   32'(rsp_cmd),   32'd2);
        calc_resp_in = 2'd1;
        calc_data_in = 32'h77;
        step();
        chk("t5_late_code", 32'(rsp_code), 32'd3);
        chk("t5_late_data", 32'(rsp_data), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        step();
        chk("t5_late_valid", 32'(rsp_valid), 32'd0);
        chk("t5_late_busy",  32'(busy),      32'd0);
        calc_resp_in = 2'd0;
        calc_data_in = '0;
        // put a fresh operation into WAIT for the reset test
        push_req(4'd5, 32'd1, 32'd4);
        step();
        step();
        step();
`else
        seen = 0;
        repeat (100) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("t5_no_tmo_valid", 32'(seen), 32'd0);
        chk("t5_no_tmo_busy",  32'(busy), 32'd1);
`endif

        // 6. reset in the middle of WAIT, then a late response
        step();
        step();
        reset = 1'b0;
        #1;
        chk_quiet("t6_rst");
        calc_resp_in = 2'd1;
        calc_data_in = 32'h10;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        step();
        chk_quiet("t6_post");
        calc_resp_in = 2'd0;
        calc_data_in = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
